arm_mc_controller: RTL and testbench

- Multicycle sequencer and decoder for the ARM processor datapath.
- Latches the fetched instruction, decodes it, and drives the datapath control lines (PCSrc, MemtoReg, ALUSrc, RegWrite, ALUControl, ImmSrc, RegSrc) across FETCH/DECODE/EXEC/MEM/RETIRE states.
- Owns the NZCV flag register and the conditional-execution check.
- Gates PC and register writes to one pulse per instruction, and runs req/ready handshakes with instruction and data memory, including a timeout trap.

---
 rtl/arm_ctrl_pkg.sv | 139 +++++++++++++
 rtl/cond_check.sv | 38 +++
 rtl/arm_mc_controller.sv | 151 +++++++++++++++
 tb/tb_arm_mc_controller.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/arm_ctrl_pkg.sv
// arm_ctrl_pkg: shared types and constants for the multicycle ARM controller.
//   - state_e    : sequencer states
//   - ALU_*      : ALUControl encodings
//   - IMM_*      : ImmSrc (extend mode) encodings
//   - OP_*       : instruction class field IR[27:26]
//   - COND_*     : condition codes IR[31:28]
//   - CMD_*      : data-processing commands funct[4:1]
//   - ctrl_t     : control fields registered in DECODE
//   - decode_ctrl / decode_illegal : pure decode helpers on the latched IR
package arm_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    RETIRE = 3'd4,
    TRAP   = 3'd5
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_MOV = 4'b0100;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic       alu_src;
    logic [1:0] imm_src;
    logic [2:0] reg_src;
    logic       mem_to_reg;
    logic       reg_we;     // instruction intends a register write
    logic       flag_we;    // NZCV is updated at the end of EXEC
    logic       is_mem;
    logic       is_store;
    logic       is_branch;
    logic       rd15;       // destination is the PC
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [31:0] ir);
    ctrl_t      c;
    logic [5:0] funct;
    logic [3:0] cmd;
    c     = '0;
    funct = ir[25:20];
    cmd   = funct[4:1];
    c.rd15 = (ir[15:12] == 4'hF);
    case (ir[27:26])
      OP_DP: begin
        c.alu_src = funct[5];
        c.flag_we = funct[0];
        c.reg_we  = 1'b1;
        case (cmd)
          CMD_ADD: c.alu_ctrl = ALU_ADD;
          CMD_SUB: c.alu_ctrl = ALU_SUB;
          CMD_AND: c.alu_ctrl = ALU_AND;
          CMD_ORR: c.alu_ctrl = ALU_ORR;
          CMD_MOV: c.alu_ctrl = ALU_MOV;
          CMD_CMP: begin
            c.alu_ctrl = ALU_SUB;
            c.reg_we   = 1'b0;
            c.flag_we  = 1'b1;
          end
          default: c.alu_ctrl = ALU_ADD;
        endcase
      end
      OP_MEM: begin
        c.alu_src  = 1'b1;
        c.imm_src  = IMM_MEM;
        c.alu_ctrl = funct[3] ? ALU_ADD : ALU_SUB;
        c.is_mem   = 1'b1;
        if (funct[0]) begin
          c.mem_to_reg = 1'b1;
          c.reg_we     = 1'b1;
        end else begin
          c.is_store = 1'b1;
          c.reg_src  = 3'b100;  // RA2 reads Rd as the store data
        end
      end
      OP_BR: begin
        c.imm_src   = IMM_BR;
        c.reg_src   = 3'b001;   // RA1 reads R15
        c.alu_src   = 1'b1;
        c.alu_ctrl  = ALU_ADD;
        c.is_branch = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic decode_illegal(input logic [31:0] ir);
    logic [3:0] cmd;
    logic       bad;
    cmd = ir[24:21];
    bad = (ir[31:28] == COND_NV) || (ir[27:26] == 2'b11);
    if (ir[27:26] == OP_DP) begin
      case (cmd)
        CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR, CMD_CMP, CMD_MOV: ;
        default: bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/cond_check.sv
// cond_check: combinational ARM condition evaluator.
//   cond    in  4  condition field IR[31:28]
//   nzcv    in  4  {N,Z,C,V} flag register
//   cond_ex out 1  instruction executes; 1111 is treated as never
module cond_check
  import arm_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       cond_ex
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_mc_controller.sv
// arm_mc_controller: multicycle sequencer/decoder for the ARM datapath.
//   clk, rst (async, active-low)
//   instr_req/instr_valid/Instr : instruction fetch handshake
//   InstrQ                      : latched IR[23:0] to the datapath
//   ALUFlags                    : {N,Z,C,V} sampled at the end of EXEC
//   mem_req/mem_ready/MemWrite  : data memory handshake
//   PCWrite, PCSrc, MemtoReg, ALUSrc, RegWrite, ALUControl, ImmSrc, RegSrc
//                               : datapath controls
//   trap                        : sticky error (illegal instr or timeout)
module arm_mc_controller
  import arm_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        instr_req,
  input  logic        instr_valid,
  input  logic [31:0] Instr,
  output logic [23:0] InstrQ,
  input  logic [3:0]  ALUFlags,
  output logic        mem_req,
  input  logic        mem_ready,
  output logic        MemWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        MemtoReg,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic [3:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [2:0]  RegSrc,
  output logic        trap
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(MEM_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [31:0]   ir_q, ir_d;
  logic [3:0]    nzcv_q, nzcv_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ctrl_t         ctrl_q, ctrl_d;
  logic          cond_ex_q, cond_ex_d;
  // Keeps instr_req low during reset and for the release cycle, so every
  // output is 0 while rst is asserted.
  logic          run_q;

  logic          cond_ex_w;
  logic          waiting;

  cond_check u_cond_check (
    .cond    (ir_q[31:28]),
    .nzcv    (nzcv_q),
    .cond_ex (cond_ex_w)
  );

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    nzcv_d    = nzcv_q;
    ctrl_d    = ctrl_q;
    cond_ex_d = cond_ex_q;
    cnt_d     = cnt_q;
    waiting   = 1'b0;
    instr_req = 1'b0;
    mem_req   = 1'b0;
    MemWrite  = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    PCSrc     = 1'b0;
    trap      = 1'b0;

    case (state_q)
      FETCH: begin
        if (run_q) begin
          instr_req = 1'b1;
          if (instr_valid) begin
            ir_d    = Instr;
            state_d = DECODE;
          end else begin
            waiting = 1'b1;
          end
        end
      end
      DECODE: begin
        ctrl_d    = decode_ctrl(ir_q);
        cond_ex_d = cond_ex_w;
        if (decode_illegal(ir_q)) state_d = TRAP;
        else if (!cond_ex_w)      state_d = RETIRE;
        else                      state_d = EXEC;
      end
      EXEC: begin
        if (ctrl_q.flag_we) nzcv_d = ALUFlags;
        state_d = ctrl_q.is_mem ? MEM : RETIRE;
      end
      MEM: begin
        mem_req  = 1'b1;
        MemWrite = ctrl_q.is_store;
        if (mem_ready) state_d = RETIRE;
        else           waiting = 1'b1;
      end
      RETIRE: begin
        PCWrite  = 1'b1;
        RegWrite = ctrl_q.reg_we & cond_ex_q;
        PCSrc    = cond_ex_q & (ctrl_q.is_branch | (ctrl_q.reg_we & ctrl_q.rd15));
        state_d  = FETCH;
      end
      TRAP: begin
        trap = 1'b1;
      end
      default: state_d = TRAP;
    endcase

    // The counter holds the number of cycles already waited; the cycle that
    // would make it reach MEM_TIMEOUT abandons the handshake instead.
    if (waiting) begin
      if (cnt_q == TMO_LAST) state_d = TRAP;
      else                   cnt_d   = cnt_q + CW'(1);
    end
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FETCH;
      ir_q      <= '0;
      nzcv_q    <= '0;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      cond_ex_q <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      nzcv_q    <= nzcv_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      cond_ex_q <= cond_ex_d;
      run_q     <= 1'b1;
    end
  end

  assign InstrQ     = ir_q[23:0];
  assign MemtoReg   = ctrl_q.mem_to_reg;
  assign ALUSrc     = ctrl_q.alu_src;
  assign ALUControl = ctrl_q.alu_ctrl;
  assign ImmSrc     = ctrl_q.imm_src;
  assign RegSrc     = ctrl_q.reg_src;

endmodule

// File: tb/tb_arm_mc_controller.sv
module tb_arm_mc_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_req, instr_valid;
  logic [31:0] Instr;
  logic [23:0] InstrQ;
  logic [3:0]  ALUFlags;
  logic        mem_req, mem_ready, MemWrite, PCWrite, PCSrc, MemtoReg, ALUSrc, RegWrite;
  logic [3:0]  ALUControl;
  logic [1:0]  ImmSrc;
  logic [2:0]  RegSrc;
  logic        trap;

  always #5 clk = ~clk;

  arm_mc_controller #(.MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .instr_req(instr_req), .instr_valid(instr_valid), .Instr(Instr), .InstrQ(InstrQ),
    .ALUFlags(ALUFlags),
    .mem_req(mem_req), .mem_ready(mem_ready), .MemWrite(MemWrite),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .MemtoReg(MemtoReg), .ALUSrc(ALUSrc),
    .RegWrite(RegWrite), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .trap(trap)
  );

  typedef struct packed {
    logic       retire;
    logic [7:0] cycles;
    logic [7:0] mem_cycles;
    logic       memw;
    logic       chk;
    logic [3:0] alu;
    logic       alu_src;
    logic [1:0] imm;
    logic [2:0] regsrc;
    logic       mtr;
    logic       rw;
    logic       pcsrc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic retire, input int cycles, input int memc,
                              input logic memw, input logic chk, input logic [3:0] alu,
                              input logic asrc, input logic [1:0] imm, input logic [2:0] rs,
                              input logic mtr, input logic rw, input logic pcs);
    exp_t e;
    e.retire = retire; e.cycles = 8'(cycles); e.mem_cycles = 8'(memc);
    e.memw = memw; e.chk = chk; e.alu = alu; e.alu_src = asrc; e.imm = imm;
    e.regsrc = rs; e.mtr = mtr; e.rw = rw; e.pcsrc = pcs;
    return e;
  endfunction

  // Waits (bounded) for instr_req, then presents one word for one cycle.
  // Returns at the negedge of the DECODE cycle.
  task automatic fetch(input string name, input logic [31:0] w, input logic [3:0] f);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (instr_req === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check({name, ":fetch_req"}, 32'(ok), 32'd1);
    Instr = w; ALUFlags = f; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  // One instruction: expectation pushed when the word is driven, popped and
  // compared when the DUT retires it or traps.
  task automatic run(input string name, input logic [31:0] w, input logic [3:0] f,
                     input int mem_wait, input exp_t e_in);
    exp_t e;
    int   cyc, memc;
    bit   done, tr, memw_seen, stray;
    sb.push_back(e_in);
    fetch(name, w, f);
    cyc = 2; memc = 0; done = 0; tr = 0; memw_seen = 0; stray = 0;
    for (int i = 0; i < 40; i++) begin
      if (PCWrite === 1'b1) begin done = 1; break; end
      if (trap === 1'b1) begin done = 1; tr = 1; break; end
      if (RegWrite !== 1'b0 || PCSrc !== 1'b0) stray = 1;
      if (MemWrite === 1'b1 && mem_req !== 1'b1) stray = 1;
      if (mem_req === 1'b1) begin
        memc++;
        if (MemWrite === 1'b1) memw_seen = 1;
        mem_ready = (memc > mem_wait);
      end
      @(negedge clk);
      cyc++;
    end
    mem_ready = 1'b0;
    e = sb.pop_front();
    check({name, ":done"}, 32'(done), 32'd1);
    check({name, ":trap"}, 32'(tr), 32'(!e.retire));
    check({name, ":mem_cycles"}, 32'(memc), 32'(e.mem_cycles));
    check({name, ":memwrite"}, 32'(memw_seen), 32'(e.memw));
    check({name, ":stray_strobe"}, 32'(stray), 32'd0);
    check({name, ":InstrQ"}, 32'(InstrQ), 32'(w[23:0]));
    if (e.retire) begin
      check({name, ":retire_cycle"}, 32'(cyc), 32'(e.cycles));
      check({name, ":RegWrite"}, 32'(RegWrite), 32'(e.rw));
      check({name, ":PCSrc"}, 32'(PCSrc), 32'(e.pcsrc));
      check({name, ":MemWrite_retire"}, 32'(MemWrite), 32'd0);
    end
    if (e.chk) begin
      check({name, ":ALUControl"}, 32'(ALUControl), 32'(e.alu));
      check({name, ":ALUSrc"}, 32'(ALUSrc), 32'(e.alu_src));
      check({name, ":ImmSrc"}, 32'(ImmSrc), 32'(e.imm));
      check({name, ":RegSrc"}, 32'(RegSrc), 32'(e.regsrc));
      check({name, ":MemtoReg"}, 32'(MemtoReg), 32'(e.mtr));
    end
    $display("txn %-10s instr=%08h retired=%0d trap=%0d cycles=%0d mem_cycles=%0d",
             name, w, !tr && done, tr, cyc, memc);
  endtask

  // Asserts reset from a negedge, checks outputs drop at once, releases.
  task automatic do_reset(input string name);
    rst = 1'b0;
    instr_valid = 1'b0;
    mem_ready = 1'b0;
    #1;
    check({name, ":rst_ctrl"},
          32'({instr_req, mem_req, MemWrite, PCWrite, PCSrc, MemtoReg, ALUSrc,
               RegWrite, ALUControl, ImmSrc, RegSrc, trap}), 32'd0);
    check({name, ":rst_InstrQ"}, 32'(InstrQ), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check({name, ":req_at_release"}, 32'(instr_req), 32'd0);
    @(negedge clk);
    check({name, ":req_after_release"}, 32'(instr_req), 32'd1);
    $display("txn %-10s reset applied and released", name);
  endtask

  initial begin
    instr_valid = 1'b0; Instr = '0; ALUFlags = '0; mem_ready = 1'b0;
    @(negedge clk);
    do_reset("por");

    run("ADD",    32'hE0821003, 4'b0000, 0, mk(1, 4, 0, 0, 1, 4'h0, 0, 2'b00, 3'b000, 0, 1, 0));
    run("SUBS_Z1", 32'hE0521003, 4'b0100, 0, mk(1, 4, 0, 0, 1, 4'h1, 0, 2'b00, 3'b000, 0, 1, 0));
    run("ADDEQ_t", 32'h00821003, 4'b0000, 0, mk(1, 4, 0, 0, 1, 4'h0, 0, 2'b00, 3'b000, 0, 1, 0));
    run("SUBS_Z0", 32'hE0521003, 4'b0000, 0, mk(1, 4, 0, 0, 1, 4'h1, 0, 2'b00, 3'b000, 0, 1, 0));
    run("ADDEQ_n", 32'h00821003, 4'b0000, 0, mk(1, 3, 0, 0, 1, 4'h0, 0, 2'b00, 3'b000, 0, 0, 0));
    run("MOV_PC", 32'hE1A0F000, 4'b0000, 0, mk(1, 4, 0, 0, 1, 4'h4, 0, 2'b00, 3'b000, 0, 1, 1));
    run("CMP_imm", 32'hE3520000, 4'b0100, 0, mk(1, 4, 0, 0, 1, 4'h1, 1, 2'b00, 3'b000, 0, 0, 0));
    run("ADDNE_n", 32'h10821003, 4'b0000, 0, mk(1, 3, 0, 0, 1, 4'h0, 0, 2'b00, 3'b000, 0, 0, 0));
    run("LDR",    32'hE5910004, 4'b0000, 3, mk(1, 8, 4, 0, 1, 4'h0, 1, 2'b01, 3'b000, 1, 1, 0));
    run("LDR_U0", 32'hE5110004, 4'b0000, 0, mk(1, 5, 1, 0, 1, 4'h1, 1, 2'b01, 3'b000, 1, 1, 0));
    run("B",      32'hEA000002, 4'b0000, 0, mk(1, 4, 0, 0, 1, 4'h0, 1, 2'b10, 3'b001, 0, 0, 1));
    run("STR_tmo", 32'hE5810004, 4'b0000, 99, mk(0, 0, 8, 1, 1, 4'h0, 1, 2'b01, 3'b100, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("trap_sticky", 32'({trap, PCWrite, RegWrite, MemWrite}), 32'b1000);
    end
    do_reset("rst_trap");

    run("UNDEF",  32'hEC000000, 4'b0000, 0, mk(0, 0, 0, 0, 0, 4'h0, 0, 2'b00, 3'b000, 0, 0, 0));
    do_reset("rst_undef");

    // Abort a load mid-MEM with Z set; the following ADDEQ must see Z=0.
    run("SUBS_Z1b", 32'hE0521003, 4'b0100, 0, mk(1, 4, 0, 0, 1, 4'h1, 0, 2'b00, 3'b000, 0, 1, 0));
    fetch("LDR_abort", 32'hE5910004, 4'b0000);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        if (mem_req === 1'b1) begin seen = 1'b1; break; end
        @(negedge clk);
      end
      @(negedge clk);
      check("abort:mem_req_held", 32'({seen, mem_req}), 32'b11);
    end
    do_reset("rst_mem");
    run("ADDEQ_nz0", 32'h00821003, 4'b0000, 0, mk(1, 3, 0, 0, 1, 4'h0, 0, 2'b00, 3'b000, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
